cdb_broadcaster: RTL and testbench

Complete-stage producer of the CDB result broadcast consumed by the ROB, reservation stations and map table. Collects finished results from NUM_FU functional units into per-FU FIFOs. Round-robin arbitrates among them and drives at most one registered broadcast (rob_tag, value, dest_reg) per cycle. Issues per-FU back-pressure and clears itself on a pipeline flush.

---
 rtl/cdb_broadcaster_pkg.sv | 23 ++
 rtl/cdb_fu_fifo.sv | 68 ++++++
 rtl/cdb_broadcaster.sv | 111 +++++++++++
 tb/tb_cdb_broadcaster.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cdb_broadcaster_pkg.sv
// Shared types and default sizes for the CDB broadcast path (FU results, ROB tags, CDB packet).
package cdb_broadcaster_pkg;
  localparam int ROB_SZ            = 8;
  localparam int ROB_TAG_WIDTH_DEF = $clog2(ROB_SZ);
  localparam int XLEN_DEF          = 32;
  localparam int REG_W             = 5;
  localparam int NUM_FU_DEF        = 4;
  localparam int FU_FIFO_DEPTH_DEF = 2;

  typedef logic [ROB_TAG_WIDTH_DEF-1:0] rob_tag_t;

  typedef struct packed {
    rob_tag_t              rob_tag;
    logic [XLEN_DEF-1:0]   value;
    logic [REG_W-1:0]      dest_reg;
  } fu_result_t;

  // Packet view the ROB takes from cdb_rob_tag/cdb_value.
  typedef struct packed {
    rob_tag_t              tag;
    logic [XLEN_DEF-1:0]   v;
  } cdb_packet_t;
endpackage

// File: rtl/cdb_fu_fifo.sv
// Single-FU result FIFO: circular buffer with head/tail/count, flush clears all pointers.
module cdb_fu_fifo
  import cdb_broadcaster_pkg::*;
#(
  parameter int DEPTH  = FU_FIFO_DEPTH_DEF,
  parameter int DATA_W = $bits(fu_result_t)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head_data
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [IDX_W-1:0]             head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic                         do_push, do_pop;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign head_data = mem_q[head_q];

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    do_push = push && !full;
    do_pop  = pop && !empty;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[tail_q] = push_data;
        tail_d        = wrap_inc(tail_q);
      end
      if (do_pop) head_d = wrap_inc(head_q);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      mem_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/cdb_broadcaster.sv
// Complete stage: per-FU result FIFOs, round-robin pick of one head per cycle, registered CDB broadcast.
module cdb_broadcaster
  import cdb_broadcaster_pkg::*;
#(
  parameter int NUM_FU        = NUM_FU_DEF,
  parameter int FU_FIFO_DEPTH = FU_FIFO_DEPTH_DEF,
  parameter int ROB_TAG_WIDTH = ROB_TAG_WIDTH_DEF,
  parameter int XLEN          = XLEN_DEF
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  flush,
  input  logic [NUM_FU-1:0]                     fu_valid,
  input  logic [NUM_FU-1:0][ROB_TAG_WIDTH-1:0]  fu_rob_tag,
  input  logic [NUM_FU-1:0][XLEN-1:0]           fu_value,
  input  logic [NUM_FU-1:0][REG_W-1:0]          fu_dest_reg,
  output logic [NUM_FU-1:0]                     fu_ready,
  output logic                                  cdb_valid,
  output logic [ROB_TAG_WIDTH-1:0]              cdb_rob_tag,
  output logic [XLEN-1:0]                       cdb_value,
  output logic [REG_W-1:0]                      cdb_dest_reg,
  output logic                                  cdb_pending
);
  localparam int ENTRY_W = ROB_TAG_WIDTH + XLEN + REG_W;
  localparam int PTR_W   = $clog2(NUM_FU);

  logic [NUM_FU-1:0]               full, empty, push, pop;
  logic [NUM_FU-1:0][ENTRY_W-1:0]  head_data;

  logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic                     cdb_valid_q, cdb_valid_d;
  logic [ROB_TAG_WIDTH-1:0] cdb_rob_tag_q, cdb_rob_tag_d;
  logic [XLEN-1:0]          cdb_value_q, cdb_value_d;
  logic [REG_W-1:0]         cdb_dest_reg_q, cdb_dest_reg_d;

  logic             found;
  logic [PTR_W-1:0] winner;
  int               arb_idx;

  // Readiness looks only at current occupancy: a full FIFO refuses even when popped this cycle.
  for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fu
    assign fu_ready[gi] = !full[gi] && reset && !flush;
    assign push[gi]     = fu_valid[gi] && fu_ready[gi];

    cdb_fu_fifo #(.DEPTH(FU_FIFO_DEPTH), .DATA_W(ENTRY_W)) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .push      (push[gi]),
      .pop       (pop[gi]),
      .push_data ({fu_rob_tag[gi], fu_value[gi], fu_dest_reg[gi]}),
      .full      (full[gi]),
      .empty     (empty[gi]),
      .head_data (head_data[gi])
    );
  end

  assign cdb_pending = |(~empty);

  // First non-empty FIFO at or above rr_ptr (mod NUM_FU) wins.
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    arb_idx = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      arb_idx = (int'(rr_ptr_q) + k) % NUM_FU;
      if (!found && !empty[arb_idx]) begin
        found  = 1'b1;
        winner = PTR_W'(arb_idx);
      end
    end
    pop = '0;
    if (found && !flush) pop[winner] = 1'b1;
  end

  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    cdb_valid_d    = 1'b0;
    cdb_rob_tag_d  = '0;
    cdb_value_d    = '0;
    cdb_dest_reg_d = '0;
    if (flush) begin
      rr_ptr_d = '0;
    end else if (found) begin
      cdb_valid_d                                  = 1'b1;
      {cdb_rob_tag_d, cdb_value_d, cdb_dest_reg_d} = head_data[winner];
      rr_ptr_d = (winner == PTR_W'(NUM_FU - 1)) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_ptr_q       <= '0;
      cdb_valid_q    <= 1'b0;
      cdb_rob_tag_q  <= '0;
      cdb_value_q    <= '0;
      cdb_dest_reg_q <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      cdb_valid_q    <= cdb_valid_d;
      cdb_rob_tag_q  <= cdb_rob_tag_d;
      cdb_value_q    <= cdb_value_d;
      cdb_dest_reg_q <= cdb_dest_reg_d;
    end
  end

  assign cdb_valid    = cdb_valid_q;
  assign cdb_rob_tag  = cdb_rob_tag_q;
  assign cdb_value    = cdb_value_q;
  assign cdb_dest_reg = cdb_dest_reg_q;
endmodule

// File: tb/tb_cdb_broadcaster.sv
// Scoreboard bench: queue-based reference of FU FIFOs and round-robin pick; monitor checks every CDB cycle.
module tb_cdb_broadcaster;
  localparam int N  = 4;
  localparam int D  = 2;
  localparam int TW = 3;
  localparam int XW = 32;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [XW-1:0] val;
    logic [4:0]    dest;
  } ent_t;

  typedef struct packed {
    logic v;
    ent_t e;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  logic [N-1:0]         fu_valid = '0;
  logic [N-1:0][TW-1:0] fu_rob_tag = '0;
  logic [N-1:0][XW-1:0] fu_value = '0;
  logic [N-1:0][4:0]    fu_dest_reg = '0;
  logic [N-1:0]         fu_ready;
  logic                 cdb_valid;
  logic [TW-1:0]        cdb_rob_tag;
  logic [XW-1:0]        cdb_value;
  logic [4:0]           cdb_dest_reg;
  logic                 cdb_pending;

  cdb_broadcaster #(.NUM_FU(N), .FU_FIFO_DEPTH(D), .ROB_TAG_WIDTH(TW), .XLEN(XW)) dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .fu_valid     (fu_valid),
    .fu_rob_tag   (fu_rob_tag),
    .fu_value     (fu_value),
    .fu_dest_reg  (fu_dest_reg),
    .fu_ready     (fu_ready),
    .cdb_valid    (cdb_valid),
    .cdb_rob_tag  (cdb_rob_tag),
    .cdb_value    (cdb_value),
    .cdb_dest_reg (cdb_dest_reg),
    .cdb_pending  (cdb_pending)
  );

  always #5 clock = ~clock;

  int   errors = 0;
  int   checks = 0;
  ent_t mq[N][$];
  int   rr = 0;
  exp_t exp_q[$];
  logic [N-1:0] pend_v = '0;
  ent_t pend[N];

  // Monitor: one expected CDB state per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (cdb_valid !== e.v || cdb_rob_tag !== e.e.tag || cdb_value !== e.e.val ||
            cdb_dest_reg !== e.e.dest) begin
          errors++;
          $display("FAIL cdb t=%0t got v=%0b tag=%0d val=%h dest=%0d exp v=%0b tag=%0d val=%h dest=%0d",
                   $time, cdb_valid, cdb_rob_tag, cdb_value, cdb_dest_reg,
                   e.v, e.e.tag, e.e.val, e.e.dest);
        end
      end
    end
  end

  function automatic logic [N-1:0] model_ready(input logic rst_i, input logic fl_i);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (mq[i].size() < D) && rst_i && !fl_i;
    return r;
  endfunction

  function automatic logic model_pending();
    logic p = 1'b0;
    for (int i = 0; i < N; i++) if (mq[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic step(input logic rst_i, input logic fl_i);
    logic [N-1:0] rdy;
    exp_t x;
    int   win;
    @(negedge clock);
    reset    = rst_i;
    flush    = fl_i;
    fu_valid = pend_v;
    for (int i = 0; i < N; i++) begin
      fu_rob_tag[i]  = pend[i].tag;
      fu_value[i]    = pend[i].val;
      fu_dest_reg[i] = pend[i].dest;
    end
    #1;
    rdy = model_ready(rst_i, fl_i);
    checks++;
    if (fu_ready !== rdy) begin
      errors++;
      $display("FAIL fu_ready t=%0t got %b exp %b", $time, fu_ready, rdy);
    end
    checks++;
    if (cdb_pending !== model_pending()) begin
      errors++;
      $display("FAIL cdb_pending t=%0t got %b exp %b", $time, cdb_pending, model_pending());
    end
    @(posedge clock);
    x = '0;
    if (!rst_i || fl_i) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      rr = 0;
    end else begin
      win = -1;
      for (int k = 0; k < N; k++)
        if (win < 0 && mq[(rr + k) % N].size() > 0) win = (rr + k) % N;
      if (win >= 0) begin
        x.v = 1'b1;
        x.e = mq[win].pop_front();
        rr  = (win + 1) % N;
      end
      for (int i = 0; i < N; i++)
        if (pend_v[i] && rdy[i]) begin
          mq[i].push_back(pend[i]);
          pend_v[i] = 1'b0;
        end
    end
    exp_q.push_back(x);
  endtask

  task automatic gen(input int rate);
    for (int i = 0; i < N; i++)
      if (!pend_v[i] && $urandom_range(0, 99) < rate) begin
        pend_v[i]    = 1'b1;
        pend[i].tag  = TW'($urandom_range(0, 7));
        pend[i].val  = $urandom;
        pend[i].dest = 5'($urandom_range(0, 31));
      end
  endtask

  task automatic load_all();
    for (int i = 0; i < N; i++) begin
      pend_v[i] = 1'b1;
      pend[i]   = '{tag: TW'(i), val: 32'h1000 + i, dest: 5'(i + 8)};
    end
  endtask

  initial begin
    int rate;
    for (int i = 0; i < N; i++) pend[i] = '0;
    step(0, 0);
    step(0, 0);
    // Single result from FU1
    pend_v[1] = 1'b1;
    pend[1]   = '{tag: 3'd3, val: 32'hDEAD_BEEF, dest: 5'd5};
    step(1, 0);
    repeat (3) step(1, 0);
    // Fairness, two bursts
    repeat (2) begin
      load_all();
      step(1, 0);
      repeat (5) step(1, 0);
    end
    // Flush with results pending and an FU0 push in the flush cycle
    load_all();
    step(1, 0);
    step(1, 0);
    pend_v[0] = 1'b1;
    pend[0]   = '{tag: 3'd7, val: 32'hBAD0_0000, dest: 5'd31};
    step(1, 1);
    pend_v = '0;
    repeat (4) step(1, 0);
    // Reset mid-broadcast, then simultaneous FU0/FU2 push
    load_all();
    step(1, 0);
    step(1, 0);
    pend_v = '0;
    step(0, 0);
    pend_v[2] = 1'b1; pend[2] = '{tag: 3'd2, val: 32'h2222, dest: 5'd2};
    pend_v[0] = 1'b1; pend[0] = '{tag: 3'd1, val: 32'h1111, dest: 5'd1};
    step(1, 0);
    repeat (4) step(1, 0);
    // Randomized traffic: saturation exercises back-pressure and wrap-around
    for (int seg = 0; seg < 12; seg++) begin
      case ($urandom_range(0, 2))
        0: rate = 20;
        1: rate = 60;
        default: rate = 100;
      endcase
      for (int c = 0; c < 50; c++) begin
        gen(rate);
        step($urandom_range(0, 99) != 0, $urandom_range(0, 99) < 3);
      end
    end
    pend_v = '0;
    repeat (12) step(1, 0);
    @(posedge clock);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d left exp 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
